ps2_key_rx: RTL and testbench
=============================

Name: ps2_key_rx

Overview:
- Converts a raw PS/2 keyboard serial stream (clock/data pins) into the 11-bit ps2_key event word that the emu top-level key decoder consumes.
- Word layout: bit 10 toggles on every event, bit 9 = pressed, bits 8:0 = {extended, scan code}.
- Sits between the user-port or keyboard pins and the game key-mapping logic in clk_sys.
- Lets a core take a physical keyboard without going through the HPS path.

Parameters:
- FILTER_LEN, 8: consecutive clk_sys cycles a synchronised ps2_clk level must hold before the filtered clock follows it.
- TIMEOUT, 24000: clk_sys cycles with no filtered falling edge after which a partial frame is abandoned (2 ms at 12 MHz).

Ports:
- clk_sys  in  1  system clock (12 MHz nominal); the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clk_sys.
- ps2_data  in  1  raw PS/2 data, asynchronous to clk_sys.
- ps2_key  out  11  {toggle, pressed, extended, code[7:0]}.
- byte_valid  out  1  one-cycle pulse: a correctly framed byte was received.
- byte_data  out  8  last correctly framed byte; held between pulses.
- frame_err  out  1  one-cycle pulse on parity error, stop-bit error or timeout.

Behaviour:
- Reset: reset_n low clears all state asynchronously.
  - ps2_key = 0, byte_data = 0, byte_valid = 0, frame_err = 0.
  - Prefix flags cleared, FSM = IDLE.
  - Filtered clock = 1, bit counter = 0, timeout counter = 0.
  - Reset mid-frame discards the partial frame; no pulse is produced.
- Input conditioning:
  - 2-FF synchroniser on each of ps2_clk and ps2_data.
  - Filter counter: clears whenever the synchronised clock equals the filtered clock; otherwise increments. When it reaches FILTER_LEN-1, the filtered clock takes the new level and the counter clears.
  - fall = one-cycle pulse on filtered 1->0.
  - Data is sampled from the synchronised ps2_data in the fall cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 (start bit) -> DATA, bit count = 0. On fall with data=1, stay in IDLE; this is not an error.
  - DATA: on each fall, shift data into the byte LSB-first and accumulate XOR. After the 8th bit -> PARITY.
  - PARITY: on fall, store the parity bit -> STOP.
  - STOP: on fall, check the frame. Frame is good iff stop bit = 1 and XOR(data[7:0], parity) = 1 (odd parity). Always return to IDLE.
- Timeout:
  - Counter clears on every fall and whenever FSM = IDLE.
  - In a non-IDLE state, reaching TIMEOUT-1 forces IDLE and pulses frame_err the next cycle.
  - A fall in the same cycle as the timeout: the fall wins and the counter clears.
- Good frame (stop-bit fall in cycle N):
  - byte_valid = 1 and byte_data = byte in cycle N+1.
  - Decode stage acts in cycle N+2:
    - byte E0: set ext flag; ps2_key unchanged.
    - byte F0: set rel flag; ps2_key unchanged.
    - any other byte (E1 included): ps2_key <= {~ps2_key[10], ~rel, ext, byte}, then clear ext and rel.
- Bad frame: frame_err = 1 in cycle N+1.
  - byte_valid stays 0 and byte_data is unchanged.
  - ext and rel are cleared, so the next byte decodes as a plain make code.
- Repeated prefixes (E0 E0, F0 F0) leave the flag set. E0 F0 and F0 E0 both yield ext = 1, rel = 1.
- byte_valid and frame_err are never high in the same cycle.
- Sustained throughput: one frame per 11 falls; no backpressure. ps2_key must be sampled by the consumer via the toggle bit.

Test Plan:
- Make code: after reset, send frame 0x1C with parity 0.
  - byte_valid pulses once with byte_data = 0x1C.
  - Two cycles after the stop fall, ps2_key = 11'b1_1_0_00011100 (0x61C).
- Break code: then send F0, 1C.
  - Only one ps2_key update.
  - ps2_key = 0x01C (toggle 0, pressed 0, ext 0).
- Extended make and break: send E0 75, then E0 F0 75.
  - First result: ps2_key = 0x775.
  - Second result: ps2_key = 0x175.
  - Toggle flips twice in total.
- Parity error: send 0x1C with parity 1.
  - frame_err pulses once; byte_valid stays 0; ps2_key unchanged.
  - A following E0 74 then decodes to ps2_key[8:0] = 0x174.
- Timeout and glitch rejection:
  - Stop the clock after 4 data bits: frame_err pulses TIMEOUT cycles after the last fall; FSM = IDLE.
  - A full frame 0x29 then yields ps2_key[7:0] = 0x29.
  - A ps2_clk low pulse of FILTER_LEN-2 cycles produces no fall and no state change.
- Reset mid-frame: assert reset_n low after the 6th fall.
  - All outputs = 0 immediately.
  - Release reset, send 0x16: ps2_key = 0x616, byte_valid pulses exactly once.

Source files
------------

// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver for clk_sys.
// Synchronises and deglitches the raw PS/2 pins, then deframes
// 11-bit frames (start, 8 data LSB-first, odd parity, stop).
// Scan codes are folded into the 11-bit ps2_key event word
// {toggle, pressed, extended, code}.
//
// Output handshake: byte_valid and frame_err are one-cycle pulses with no
// backpressure. byte_data is held between pulses. ps2_key changes only one
// cycle after a byte_valid pulse, and a consumer detects each new event by
// watching bit 10 toggle.
module ps2_key_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 24000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t         state;
    logic           clk_meta, clk_sync;
    logic           data_meta, data_sync;
    logic           clk_filt, clk_filt_d;
    logic [FW-1:0]  filt_cnt;
    logic           fall;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;
    logic           par_acc;
    logic           par_bit;
    logic [TW-1:0]  tmo_cnt;
    logic           timeout_hit;
    logic           ext, rel;

    // Two-flop synchronisers; idle-high so reset never fakes a falling edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    // Clock deglitch: the filtered clock follows only after FILTER_LEN stable cycles.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_sync == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_MAX) begin
                clk_filt <= clk_sync;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall        = clk_filt_d & ~clk_filt;
    // A falling edge in the same cycle rescues the frame from the timeout.
    assign timeout_hit = (state != IDLE) && (tmo_cnt == TMO_MAX) && !fall;

    // Frame receiver FSM with inactivity timeout and registered result pulses.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_acc    <= 1'b0;
            par_bit    <= 1'b0;
            tmo_cnt    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall || state == IDLE) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (timeout_hit) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!data_sync) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            par_acc <= 1'b0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_sync, shift[7:1]};
                        par_acc <= par_acc ^ data_sync;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= data_sync;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (data_sync && (par_acc ^ par_bit)) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Key decode: E0/F0 set prefix flags, any other byte emits an event.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ext     <= 1'b0;
            rel     <= 1'b0;
            ps2_key <= '0;
        end else if (frame_err) begin
            ext <= 1'b0;
            rel <= 1'b0;
        end else if (byte_valid) begin
            if (byte_data == 8'hE0) begin
                ext <= 1'b1;
            end else if (byte_data == 8'hF0) begin
                rel <= 1'b1;
            end else begin
                ps2_key <= {~ps2_key[10], ~rel, ext, byte_data};
                ext     <= 1'b0;
                rel     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: directed PS/2 frames, an event-level key model
// checked every cycle, and literal expectations for each scenario.
module tb_ps2_key_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 24000;
  localparam int HALF       = 30;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b1;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int last_err_cyc = -1;
  int err_pulses = 0;

  logic [7:0]  exp_q[$];
  int          exp_err = 0;
  logic [10:0] m_key = '0;
  logic        m_ext = 1'b0;
  logic        m_rel = 1'b0;
  logic [7:0]  m_byte = '0;

  ps2_key_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_key    (ps2_key),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  // clock / reset block
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // scoreboard: event-level model of the key word, compared every cycle
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      check("reset ps2_key", 32'(ps2_key), 32'h0);
      check("reset byte_valid", 32'(byte_valid), 32'h0);
      check("reset frame_err", 32'(frame_err), 32'h0);
      check("reset byte_data", 32'(byte_data), 32'h0);
      m_key = '0;
      m_ext = 1'b0;
      m_rel = 1'b0;
      m_byte = '0;
    end else begin
      check("ps2_key vs model", 32'(ps2_key), 32'(m_key));
      check("valid/err exclusive", 32'(byte_valid & frame_err), 32'h0);
      if (byte_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected byte_valid", 32'h1, 32'h0);
        end else begin
          m_byte = exp_q.pop_front();
          check("byte_data on valid", 32'(byte_data), 32'(m_byte));
          if (m_byte == 8'hE0) m_ext = 1'b1;
          else if (m_byte == 8'hF0) m_rel = 1'b1;
          else begin
            m_key = {~m_key[10], ~m_rel, m_ext, m_byte};
            m_ext = 1'b0;
            m_rel = 1'b0;
          end
        end
      end else begin
        check("byte_data held", 32'(byte_data), 32'(m_byte));
      end
      if (frame_err) begin
        err_pulses++;
        last_err_cyc = cyc;
        if (exp_err == 0) check("unexpected frame_err", 32'h1, 32'h0);
        else exp_err--;
        m_ext = 1'b0;
        m_rel = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic par_ok, input logic stop);
    logic par;
    par = par_ok ? ~^b : ^b;
    return {stop, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int nfalls, input int glitch_after);
    for (int i = 0; i < nfalls; i++) begin
      ps2_data = frame[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
      if (i == glitch_after) begin
        wait_cycles(10);
        ps2_clk = 1'b0;
        wait_cycles(FILTER_LEN - 2);
        ps2_clk = 1'b1;
      end
    end
    ps2_data = 1'b1;
    wait_cycles(HALF);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop, input int glitch_after);
    if (par_ok && stop) exp_q.push_back(b);
    else exp_err++;
    send_bits(make_frame(b, par_ok, stop), 11, glitch_after);
  endtask

  task automatic send_key(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b1, -1);
  endtask

  int delta;

  initial begin
    #2 reset_n = 1'b0;
    wait_cycles(5);
    check("reset ps2_key literal", 32'(ps2_key), 32'h0);
    reset_n = 1'b1;
    wait_cycles(5);

    // make code
    send_key(8'h1C);
    check("make 1C", 32'(ps2_key), 32'h61C);
    check("make 1C byte_data", 32'(byte_data), 32'h1C);

    // break code
    send_key(8'hF0);
    check("F0 prefix no update", 32'(ps2_key), 32'h61C);
    send_key(8'h1C);
    check("break 1C", 32'(ps2_key), 32'h01C);

    // extended make and break
    send_key(8'hE0);
    send_key(8'h75);
    check("ext make 75", 32'(ps2_key), 32'h775);
    send_key(8'hE0);
    send_key(8'hF0);
    send_key(8'h75);
    check("ext break 75", 32'(ps2_key), 32'h175);

    // parity error
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check("parity err key held", 32'(ps2_key), 32'h175);
    check("parity err pulse count", 32'(err_pulses), 32'h1);
    check("parity err byte_data held", 32'(byte_data), 32'h75);
    send_key(8'hE0);
    send_key(8'h74);
    check("after err E0 74", 32'(ps2_key[8:0]), 32'h174);

    // bad frame clears a pending prefix
    send_key(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    send_key(8'h14);
    check("prefix cleared by err", 32'(ps2_key), 32'h214);

    // stop-bit error
    send_frame(8'h33, 1'b1, 1'b0, -1);
    check("stop err key held", 32'(ps2_key), 32'h214);
    check("stop err pulse count", 32'(err_pulses), 32'h3);

    // timeout after start + 4 data bits
    exp_err++;
    send_bits(make_frame(8'h5A, 1'b1, 1'b1), 5, -1);
    wait_cycles(TIMEOUT + 40);
    delta = last_err_cyc - last_fall_cyc;
    check("timeout fired", 32'(err_pulses), 32'h4);
    check("timeout latency in window",
          32'((delta >= TIMEOUT + 10) && (delta <= TIMEOUT + 12)), 32'h1);
    if (!((delta >= TIMEOUT + 10) && (delta <= TIMEOUT + 12)))
      $display("  timeout latency was %0d cycles after clock drive", delta);

    // full frame with a short glitch mid-frame
    send_frame(8'h29, 1'b1, 1'b1, 3);
    check("glitch frame 29 low byte", 32'(ps2_key[7:0]), 32'h29);
    check("glitch frame 29", 32'(ps2_key), 32'h629);

    // repeated prefixes
    send_key(8'hE0);
    send_key(8'hE0);
    send_key(8'hF0);
    send_key(8'h14);
    check("E0 E0 F0 14", 32'(ps2_key), 32'h114);

    // reset mid-frame
    send_bits(make_frame(8'h5A, 1'b1, 1'b1), 6, -1);
    reset_n = 1'b0;
    #1;
    check("midframe reset ps2_key", 32'(ps2_key), 32'h0);
    check("midframe reset byte_data", 32'(byte_data), 32'h0);
    check("midframe reset byte_valid", 32'(byte_valid), 32'h0);
    check("midframe reset frame_err", 32'(frame_err), 32'h0);
    wait_cycles(5);
    reset_n = 1'b1;
    wait_cycles(10);
    send_key(8'h16);
    check("post reset 16", 32'(ps2_key), 32'h616);

    wait_cycles(20);
    check("expected bytes drained", 32'(exp_q.size()), 32'h0);
    check("expected errors drained", 32'(exp_err), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
